cell_mem_port_arbiter: RTL

Arbitrates port B of the cell-state frame memory between two requesters. The VGA display fetch unit is read-only and has priority. The automaton update engine issues reads and writes. The arbiter drives the Avalon-style memory command (address_b_1, read1, write1) and honours wait_request. It routes returned read data to the owning requester using a latency-matched tag pipe, and it bounds engine starvation.

---
 rtl/cell_mem_pkg.sv | 28 ++
 rtl/mem_read_tag_pipe.sv | 36 +++
 rtl/cell_mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cell_mem_pkg.sv
// Shared types for the cell-state frame memory port-B arbiter.
//   owner_e     : which requester owns a command or a returning read
//   arb_state_e : arbiter FSM states
//   tag_t       : one read-tag pipe stage {valid, owner}
package cell_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 20;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_ENG  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DISP,
        HOLD_ENG
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_DISP};

endpackage

// File: rtl/mem_read_tag_pipe.sv
// Latency-matched tag shift register for memory reads.
// A tag pushed in the cycle a read is accepted appears at tail_o exactly
// READ_LATENCY cycles later, aligned with the memory's read data.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears all stages
//   push_i : tag entering the pipe this cycle
//   tail_o : tag leaving the pipe this cycle
module mem_read_tag_pipe
    import cell_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  tag_t push_i,
    output tag_t tail_o
);

    tag_t stage_q [READ_LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q[0] <= push_i;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/cell_mem_port_arbiter.sv
// Port-B arbiter for the cell-state frame memory.
// Display fetch (read-only) has priority; the automaton engine (read/write)
// is guaranteed a grant after at most MAX_DISP_BURST consecutive display
// grants while it waits. Commands are held stable across wait_request and
// read data is steered back to its owner through a latency-matched tag pipe.
//   clk, reset                       : clock, async active-high reset
//   disp_req/addr -> disp_gnt        : display read command handshake
//   disp_rvalid/rdata                : display read return
//   eng_req/we/addr/wdata -> eng_gnt : engine command handshake
//   eng_rvalid/rdata                 : engine read return
//   address_b_1/read1/write1/writedata_b_1, q_b_1, wait_request : memory side
module cell_mem_port_arbiter
    import cell_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned MAX_DISP_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic [ADDR_W-1:0] address_b_1,
    output logic              read1,
    output logic              write1,
    output logic [DATA_W-1:0] writedata_b_1,
    input  logic [DATA_W-1:0] q_b_1,
    input  logic              wait_request
);

    localparam int unsigned STREAK_W = $clog2(MAX_DISP_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DISP_BURST);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic present;   // a command is driven onto the memory this cycle
    logic sel_eng;   // that command belongs to the engine
    logic accept;
    logic cmd_we;
    tag_t push_tag;
    tag_t tail_tag;

    // Winner selection; HOLD states keep their owner without re-arbitrating.
    // Everything is masked during reset so outputs drop to 0 immediately.
    always_comb begin : select
        present = 1'b0;
        sel_eng = 1'b0;
        case (state_q)
            IDLE: begin
                if (disp_req && !(eng_req && streak_q == STREAK_MAX)) begin
                    present = 1'b1;
                end else if (eng_req) begin
                    present = 1'b1;
                    sel_eng = 1'b1;
                end
            end
            HOLD_DISP: present = disp_req;
            HOLD_ENG: begin
                present = eng_req;
                sel_eng = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            present = 1'b0;
        end
    end

    assign accept = present && !wait_request;

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin : next_state
        // A stalled command parks in HOLD; acceptance, an idle cycle or a
        // dropped request in HOLD all return to IDLE.
        state_d = IDLE;
        if (present && wait_request) begin
            state_d = sel_eng ? HOLD_ENG : HOLD_DISP;
        end

        streak_d = streak_q;
        if (!eng_req || (accept && sel_eng)) begin
            streak_d = '0;
        end else if (accept && !sel_eng && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end

        addr_d  = address_b_1;
        wdata_d = writedata_b_1;
    end

    always_comb begin : outputs
        cmd_we        = sel_eng && eng_we;
        disp_gnt      = accept && !sel_eng;
        eng_gnt       = accept && sel_eng;
        read1         = present && !cmd_we;
        write1        = present && cmd_we;
        address_b_1   = addr_q;
        writedata_b_1 = wdata_q;
        if (present) begin
            address_b_1 = sel_eng ? eng_addr : disp_addr;
            if (sel_eng) begin
                writedata_b_1 = eng_wdata;
            end
        end

        push_tag.valid = accept && !cmd_we;
        push_tag.owner = sel_eng ? OWN_ENG : OWN_DISP;

        disp_rvalid = tail_tag.valid && (tail_tag.owner == OWN_DISP);
        eng_rvalid  = tail_tag.valid && (tail_tag.owner == OWN_ENG);
        disp_rdata  = disp_rvalid ? q_b_1 : '0;
        eng_rdata   = eng_rvalid ? q_b_1 : '0;
    end

    mem_read_tag_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_tag_pipe (
        .clk_i  (clk),
        .rst_i  (reset),
        .push_i (push_tag),
        .tail_o (tail_tag)
    );

endmodule
